// File: rtl/uart_div_pkg.sv
// rtl/uart_div_pkg.sv - shared types and constants for the UART divide sequencer
package uart_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_DIV_START,
    ST_DIV_WAIT,
    ST_TX_LOAD,
    ST_TX_WAIT
  } state_e;

  // Byte index within a frame or response; covers DATA_W up to 256.
  localparam int CNT_W = 6;

  // Quotient reported for a divide-by-zero frame, sliced to DATA_W by users.
  localparam logic [255:0] ERR_QUOTIENT = '1;

endpackage

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - inter-byte gap counter, instantiated only with RX_TIMEOUT_EN
module uart_gap_timer #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic restart_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || restart_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i && !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_div_sequencer.sv
// rtl/uart_div_sequencer.sv - receives A,B over UART, runs the divider, returns Q,R
// Optional RX_TIMEOUT_EN adds an inter-byte gap timeout that aborts partial frames.
module uart_div_sequencer
  import uart_div_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              div_start,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_q,
  input  logic [DATA_W-1:0] div_r,
  output logic [DATA_W-1:0] result_led,
  output logic              err,
  output logic              busy
);

  localparam int FRAME_BYTES = 2 * DATA_W / 8;
  localparam int IDX_W = $clog2(2 * DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

  if ((DATA_W % 8) != 0 || DATA_W > 256 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("uart_div_sequencer: unsupported DATA_W or TIMEOUT_CYC");
  end

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   frame_q, frame_d;   // {B, A}
  logic [2*DATA_W-1:0]   resp_q, resp_d;     // {R, Q}
  logic [DATA_W-1:0]     led_q, led_d;
  logic                  err_q, err_d;
  logic                  seen_busy_q, seen_busy_d;
  logic                  rx_timeout;
  logic [IDX_W-1:0]      byte_bit;
  logic [DATA_W-1:0]     op_a, op_b;

  assign op_a     = frame_q[DATA_W-1:0];
  assign op_b     = frame_q[2*DATA_W-1:DATA_W];
  assign byte_bit = IDX_W'({cnt_q, 3'b000});

`ifdef RX_TIMEOUT_EN
  uart_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .run_i    (state_q == ST_RX),
    .restart_i(rx_valid),
    .expired_o(rx_timeout)
  );
`else
  assign rx_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    resp_d      = resp_q;
    led_d       = led_q;
    err_d       = err_q;
    seen_busy_d = seen_busy_q;
    div_start   = 1'b0;
    tx_start    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          frame_d      = '0;
          frame_d[7:0] = rx_data;
          err_d        = 1'b0;
          cnt_d        = CNT_W'(1);
          state_d      = ST_RX;
        end
      end
      ST_RX: begin
        if (rx_valid) begin
          frame_d[byte_bit +: 8] = rx_data;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_DIV_START;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (rx_timeout) begin
          frame_d = '0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DIV_START: begin
        if (op_b != '0) begin
          div_start = 1'b1;
          state_d   = ST_DIV_WAIT;
        end else begin
          resp_d  = {op_a, ERR_QUOTIENT[DATA_W-1:0]};
          err_d   = 1'b1;
          state_d = ST_TX_LOAD;
        end
      end
      ST_DIV_WAIT: begin
        if (div_done) begin
          resp_d  = {div_r, div_q};
          led_d   = div_q;
          state_d = ST_TX_LOAD;
        end
      end
      ST_TX_LOAD: begin
        if (!tx_busy) begin
          tx_start    = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        // A byte is done only after busy has been seen high and then low.
        if (tx_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_TX_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      frame_q     <= '0;
      resp_q      <= '0;
      led_q       <= '0;
      err_q       <= 1'b0;
      seen_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      resp_q      <= resp_d;
      led_q       <= led_d;
      err_q       <= err_d;
      seen_busy_q <= seen_busy_d;
    end
  end

  assign tx_data    = (state_q == ST_TX_LOAD || state_q == ST_TX_WAIT) ? resp_q[byte_bit +: 8] : 8'h00;
  assign div_a      = op_a;
  assign div_b      = op_b;
  assign result_led = led_q;
  assign err        = err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
